ctrl_trace_encoder: RTL and testbench

- Retirement-trace encoder; the inverse direction of the opcode-to-control decoder.
- Each cycle an instruction retires, samples the 11 control signals, the ALU function select and the PC. Re-encodes them to the 4-bit opcode, flags illegal patterns, and buffers records in a FIFO.
- Drains records over a valid/ready stream to the debug/trace port; doubles as a run-time consistency checker on the control path.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/trace_fifo.sv | 46 ++++
 rtl/ctrl_trace_encoder.sv | 76 +++++++
 tb/tb_ctrl_trace_encoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-bit indices, golden control patterns and ALU function codes
package ctrl_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD  = 4'b0000;
    localparam opcode_t OP_SUB  = 4'b0001;
    localparam opcode_t OP_AND  = 4'b0010;
    localparam opcode_t OP_OR   = 4'b0011;
    localparam opcode_t OP_ADDI = 4'b0100;
    localparam opcode_t OP_ANDI = 4'b0101;
    localparam opcode_t OP_SLT  = 4'b0110;
    localparam opcode_t OP_LW   = 4'b0111;
    localparam opcode_t OP_SW   = 4'b1000;
    localparam opcode_t OP_J    = 4'b1001;
    localparam opcode_t OP_BEQ  = 4'b1010;
    localparam opcode_t OP_LEA  = 4'b1011;
    localparam opcode_t OP_MVS  = 4'b1100;
    localparam opcode_t OP_NOP  = 4'b1101;
    localparam opcode_t OP_ILL  = 4'b1111;

    localparam int CTRL_REGDST   = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_EXTD     = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_MVS      = 1;
    localparam int CTRL_LEA      = 0;

    localparam logic [10:0] CTRL_RTYPE = 11'b11000000000;
    localparam logic [10:0] CTRL_ADDI  = 11'b01110000000;
    localparam logic [10:0] CTRL_ANDI  = 11'b01010000000;
    localparam logic [10:0] CTRL_LW    = 11'b01111010000;
    localparam logic [10:0] CTRL_SW    = 11'b00110100000;
    localparam logic [10:0] CTRL_J     = 11'b00000000100;
    localparam logic [10:0] CTRL_BEQ   = 11'b00100001000;
    localparam logic [10:0] CTRL_LEA_P = 11'b01010000001;
    localparam logic [10:0] CTRL_MVS_P = 11'b11000000010;
    localparam logic [10:0] CTRL_NOP   = 11'b00000000000;

    localparam logic [2:0] ALU_FN_ADD = 3'd0;
    localparam logic [2:0] ALU_FN_SUB = 3'd1;
    localparam logic [2:0] ALU_FN_AND = 3'd2;
    localparam logic [2:0] ALU_FN_OR  = 3'd3;
    localparam logic [2:0] ALU_FN_SLT = 3'd4;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO, push accepted when full only alongside a pop
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic doPush, doPop;

    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = empty ? '0 : mem[rdPtr];

    // pointers wrap naturally at DEPTH; occupancy tracks pushes minus pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // storage write, no reset needed since the head is masked when empty
    always_ff @(posedge clk) begin
        if (doPush && !rst) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/ctrl_trace_encoder.sv
// ctrl_trace_encoder: re-encodes retired control signals to opcodes and streams trace records
module ctrl_trace_encoder
    import ctrl_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire,
    input  logic [10:0]       ctrl,
    input  logic [2:0]        alu_fn,
    input  logic [PC_W-1:0]   pc,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [PC_W+4:0]   tr_data,
    output logic              ovf,
    output logic [CNT_W-1:0]  drop_cnt,
    input  logic              clr_ovf
);
    opcode_t opcode;
    logic err, full, empty, drop;

    // map the control pattern back to its opcode; anything unknown is illegal
    always_comb begin
        opcode = OP_ILL;
        case (ctrl)
            CTRL_RTYPE: opcode = alu_fn == ALU_FN_ADD ? OP_ADD :
                                 alu_fn == ALU_FN_SUB ? OP_SUB :
                                 alu_fn == ALU_FN_AND ? OP_AND :
                                 alu_fn == ALU_FN_OR  ? OP_OR  :
                                 alu_fn == ALU_FN_SLT ? OP_SLT : OP_ILL;
            CTRL_ADDI:  opcode = OP_ADDI;
            CTRL_ANDI:  opcode = OP_ANDI;
            CTRL_LW:    opcode = OP_LW;
            CTRL_SW:    opcode = OP_SW;
            CTRL_J:     opcode = OP_J;
            CTRL_BEQ:   opcode = OP_BEQ;
            CTRL_LEA_P: opcode = OP_LEA;
            CTRL_MVS_P: opcode = OP_MVS;
            CTRL_NOP:   opcode = OP_NOP;
            default:    opcode = OP_ILL;
        endcase
    end

    assign err      = opcode == OP_ILL;
    assign tr_valid = !empty;
    assign drop     = retire && full && !tr_ready;

    trace_fifo #(.WIDTH(PC_W + 5), .DEPTH(DEPTH)) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (retire),
        .pop   (tr_ready),
        .din   ({err, opcode, pc}),
        .dout  (tr_data),
        .full  (full),
        .empty (empty)
    );

    // sticky overflow flag and saturating drop counter; clear beats a same-cycle drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// tb_ctrl_trace_encoder: directed self-checking bench for the retirement-trace encoder
module tb_ctrl_trace_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire = 1'b0;
    logic [10:0] ctrl = '0;
    logic [2:0]  alu_fn = '0;
    logic [31:0] pc = '0;
    logic        tr_valid;
    logic        tr_ready = 1'b0;
    logic [36:0] tr_data;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        clr_ovf = 1'b0;

    int assertCount = 0;
    int failCount = 0;

    ctrl_trace_encoder #(.PC_W(32), .DEPTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .retire   (retire),
        .ctrl     (ctrl),
        .alu_fn   (alu_fn),
        .pc       (pc),
        .tr_valid (tr_valid),
        .tr_ready (tr_ready),
        .tr_data  (tr_data),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        assert (got === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] rec(input logic e, input logic [3:0] op, input logic [31:0] p);
        return {e, op, p};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rOps [5];
        rOps = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110};
        #12;
        check("rst_valid", 64'(tr_valid), 64'd0);
        check("rst_data", 64'(tr_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        ctrl = 11'b01111010000;
        pc = 32'h40;
        retire = 1'b1;
        tick;
        retire = 1'b0;
        check("lw_valid", 64'(tr_valid), 64'd1);
        check("lw_data", 64'(tr_data), 64'(rec(1'b0, 4'b0111, 32'h40)));
        tr_ready = 1'b1;
        tick;
        check("lw_popped", 64'(tr_valid), 64'd0);
        retire = 1'b1;
        ctrl = 11'b11000000000;
        for (int i = 0; i < 5; i++) begin
            alu_fn = 3'(i);
            pc = 32'(4 * i);
            tick;
            check($sformatf("rtype_%0d", i), 64'(tr_data), 64'(rec(1'b0, rOps[i], 32'(4 * i))));
        end
        alu_fn = 3'd6;
        pc = 32'h14;
        tick;
        check("rtype_fn6", 64'(tr_data), 64'(rec(1'b1, 4'b1111, 32'h14)));
        ctrl = 11'b01000000001;
        pc = 32'h18;
        tick;
        check("illegal", 64'(tr_data), 64'(rec(1'b1, 4'b1111, 32'h18)));
        ctrl = 11'b00000000000;
        pc = 32'h1c;
        tick;
        check("nop", 64'(tr_data), 64'(rec(1'b0, 4'b1101, 32'h1c)));
        retire = 1'b0;
        tick;
        check("stream_empty", 64'(tr_valid), 64'd0);
        tr_ready = 1'b0;
        retire = 1'b1;
        ctrl = 11'b01110000000;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h100 + 32'(4 * i);
            tick;
        end
        retire = 1'b0;
        check("ovf_set", 64'(ovf), 64'd1);
        check("drop_two", 64'(drop_cnt), 64'd2);
        check("full_valid", 64'(tr_valid), 64'd1);
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 64'(tr_data), 64'(rec(1'b0, 4'b0100, 32'h100 + 32'(4 * i))));
            tick;
        end
        check("drained", 64'(tr_valid), 64'd0);
        tr_ready = 1'b0;
        retire = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'h300 + 32'(4 * i);
            tick;
        end
        check("refill_drop", 64'(drop_cnt), 64'd2);
        tr_ready = 1'b1;
        pc = 32'h400;
        tick;
        check("pushpop_drop", 64'(drop_cnt), 64'd2);
        check("pushpop_ovf", 64'(ovf), 64'd1);
        check("pushpop_head", 64'(tr_data), 64'(rec(1'b0, 4'b0100, 32'h304)));
        tr_ready = 1'b0;
        clr_ovf = 1'b1;
        pc = 32'h500;
        tick;
        clr_ovf = 1'b0;
        retire = 1'b0;
        check("clr_ovf", 64'(ovf), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain2_%0d", i), 64'(tr_data),
                  64'(rec(1'b0, 4'b0100, i < 7 ? 32'h304 + 32'(4 * i) : 32'h400)));
            tick;
        end
        check("drained2", 64'(tr_valid), 64'd0);
        tr_ready = 1'b0;
        retire = 1'b1;
        ctrl = 11'b00000000000;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h600 + 32'(4 * i);
            tick;
        end
        retire = 1'b0;
        check("pending3", 64'(tr_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 64'(tr_valid), 64'd0);
        check("async_data", 64'(tr_data), 64'd0);
        retire = 1'b1;
        tr_ready = 1'b1;
        tick;
        tick;
        check("in_rst_valid", 64'(tr_valid), 64'd0);
        tr_ready = 1'b0;
        ctrl = 11'b00000000100;
        pc = 32'h700;
        rst = 1'b0;
        tick;
        retire = 1'b0;
        check("post_rst_data", 64'(tr_data), 64'(rec(1'b0, 4'b1001, 32'h700)));
        tr_ready = 1'b1;
        tick;
        check("post_rst_sole", 64'(tr_valid), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
